fabric_data_slave: RTL
======================

Name: fabric_data_slave

Overview:
Memory-side slave on the data fabric. It sits directly downstream of the per-core code loader and L1 write-back master. It accepts an address phase, then a single-block write or a burst of block reads. It acknowledges each phase with a rising edge on BUSY_line_SLAVE and holds a 2**ADDR_W x 4*SEG_W block RAM.

Parameters:
SEG_W, 8, width of each segment lane (SA_D3, SB_D2, SC_D1, IP_D0).
ADDR_W, 10, block-address width; RAM depth is 2**ADDR_W blocks.
ACK_DELAY, 2, cycles BUSY_line_SLAVE is held low before acknowledging an address or write phase (legal range 1..15).
BEAT_GAP, 2, low cycles between read beats (legal range 2..15).

Ports:
CLK_B  in  1  fabric clock; the only clock in the block.
RESET  in  1  synchronous, active-high reset.
ADDRFD  in  1  address-phase strobe from the master.
WRITEFD  in  1  write-phase strobe from the master.
READFD  in  1  read-phase strobe from the master.
BUSY_line_MASTER  in  1  low while the master owns the lanes; qualifies ADDRFD and WRITEFD.
BUSY_line_SLAVE  out  1  high = idle/ack; each 0->1 edge acknowledges a phase or a beat.
SA_D3  inout  SEG_W  lane 3, carrying address or data.
SB_D2  inout  SEG_W  lane 2.
SC_D1  inout  SEG_W  lane 1.
IP_D0  inout  SEG_W  lane 0.
PROT_ERR  out  1  one-cycle pulse on a protocol violation.
BEAT_CNT  out  ADDR_W+1  read beats issued in the current read phase.

Behaviour:
- Bus-level conventions:
  - Strobes are pulled down at fabric level. The block treats them as active-high levels sampled at posedge CLK_B.
  - Lane data is the concatenation {SA_D3,SB_D2,SC_D1,IP_D0}, with SA_D3 as the MSBs.
  - PTR is the low ADDR_W bits of the lane concatenation latched during the address phase.
- Reset (synchronous, active-high):
  - State = IDLE, BUSY_line_SLAVE=1, PROT_ERR=0, BEAT_CNT=0, PTR=0, ptr_valid=0.
  - Lanes are released to Z. RAM contents are not cleared.
  - Reset asserted mid-phase aborts the phase in the same cycle; no acknowledge edge is produced.
- Lane drive:
  - Lanes are driven with RDATA only while READFD=1 and state is OPEN or READ. Otherwise they are Z.
  - The enable is combinational from READFD, so data is valid in the same cycle READFD rises.
- IDLE / OPEN:
  - BUSY_line_SLAVE=1 in both states. OPEN means PTR is valid.
  - ADDRFD=1 with BUSY_line_MASTER=0: latch PTR, set BUSY=0, go to AWAIT.
  - ADDRFD priority: if WRITEFD or READFD is high in the same cycle, ADDRFD wins and PROT_ERR pulses.
  - In OPEN only, WRITEFD=1 with BUSY_line_MASTER=0: RAM[PTR] <= lanes in that cycle, set BUSY=0, go to WAWAIT. PTR is unchanged.
  - In OPEN only, READFD=1: clear BEAT_CNT, set BUSY=0, go to READ.
  - WRITEFD or READFD while in IDLE: ignored, PROT_ERR pulses.
  - ADDRFD or WRITEFD with BUSY_line_MASTER=1: ignored, no error.
- AWAIT:
  - RAM read of PTR is issued on entry; RDATA is registered one cycle later.
  - After ACK_DELAY cycles with BUSY=0, drive BUSY=1 and go to OPEN.
  - Total latency from the ADDRFD sample to the rising BUSY edge is ACK_DELAY+1 cycles.
  - RDATA = RAM[PTR] is guaranteed valid before the edge.
- WAWAIT:
  - After ACK_DELAY cycles, drive BUSY=1 and go to OPEN.
  - RDATA is refreshed from RAM[PTR], so a read after a write returns the new data.
- READ, per beat:
  - Hold BUSY=0 for BEAT_GAP cycles.
  - Then drive BUSY=1 for exactly 1 cycle (the beat) with RDATA=RAM[PTR] stable through the whole beat cycle.
  - On the cycle after the beat: PTR <= PTR+1 mod 2**ADDR_W, issue the RAM read, increment BEAT_CNT.
  - BEAT_CNT saturates at 2**ADDR_W.
  - The first beat carries the block at the latched address.
- Read termination:
  - READFD seen low in any READ cycle: go to OPEN next cycle, BUSY=1, no further beat.
  - PTR keeps its post-increment value; BEAT_CNT holds until the next read phase.
  - If READFD drops during a beat cycle, the beat completes normally and the increment still happens.
- Wrap-around: PTR wraps from 2**ADDR_W-1 to 0 silently.

Test Plan:
- Write then read: ADDRFD with lanes {0x00,0x00,0x01,0x23}, BUSY_MASTER=0 -> BUSY low 2 cycles, rising at cycle 3, PTR=0x123. Then WRITEFD with lanes {A1,B2,C3,D4} -> RAM[0x123]=0xA1B2C3D4 and an ack edge 3 cycles later. Then READFD held -> lanes read 0xA1B2C3D4 in the same cycle.
- Burst read: preload RAM[0x010..0x013]=1,2,3,4, address 0x010, READFD held 20 cycles -> beats every 3 cycles carry 1,2,3,4 in order, BEAT_CNT=4 after 4 beats. Drop READFD -> OPEN, BUSY=1, PTR=0x014.
- Wrap: address 0x3FF, burst of 2 beats -> data RAM[0x3FF] then RAM[0x000], PTR=0x001.
- Protocol errors: WRITEFD from IDLE after reset -> PROT_ERR 1-cycle pulse, RAM unchanged, BUSY stays 1. ADDRFD+WRITEFD together -> address taken, PROT_ERR pulse, no write.
- Reset mid-burst: RESET during the BUSY=0 gap of the 2nd beat -> next cycle BUSY=1, lanes Z, BEAT_CNT=0. A subsequent READFD without a new address -> PROT_ERR.
- Master qualification: ADDRFD with BUSY_line_MASTER=1 -> no latch, no BUSY drop, no error.

Source files
------------

// File: rtl/fabric_data_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fabric_data_slave                                            |
// | Description : Memory-side data-fabric slave. Takes an address phase, then  |
// |               a single-block write or a paced burst of block reads, and    |
// |               acknowledges each phase/beat with a rising BUSY_line_SLAVE.  |
// |               Holds a 2**ADDR_W x 4*SEG_W block RAM.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fabric_data_slave #(
   parameter int SEG_W     = 8,
   parameter int ADDR_W    = 10,
   parameter int ACK_DELAY = 2,   // 1..15
   parameter int BEAT_GAP  = 2    // 2..15
) (
   input  logic              CLK_B,
   input  logic              RESET,
   input  logic              ADDRFD,
   input  logic              WRITEFD,
   input  logic              READFD,
   input  logic              BUSY_line_MASTER,
   output logic              BUSY_line_SLAVE,
   inout  wire  [SEG_W-1:0]  SA_D3,
   inout  wire  [SEG_W-1:0]  SB_D2,
   inout  wire  [SEG_W-1:0]  SC_D1,
   inout  wire  [SEG_W-1:0]  IP_D0,
   output logic              PROT_ERR,
   output logic [ADDR_W:0]   BEAT_CNT
);

   localparam int              DATA_W     = 4 * SEG_W;
   localparam int              DEPTH      = 1 << ADDR_W;
   localparam logic [3:0]      c_ack_last = 4'(ACK_DELAY - 1);
   localparam logic [3:0]      c_gap_last = 4'(BEAT_GAP - 1);
   localparam logic [ADDR_W:0] c_beat_max = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,   // no valid pointer
      S_OPEN   = 3'd1,   // pointer valid, waiting for a phase
      S_AWAIT  = 3'd2,   // address phase acknowledge delay
      S_WAWAIT = 3'd3,   // write phase acknowledge delay
      S_READ   = 3'd4    // read burst in progress
   } state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                prot_err_q, prot_err_d;
   logic [ADDR_W:0]     beat_cnt_q, beat_cnt_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [3:0]          dly_q, dly_d;       // shared ack-delay / beat-gap counter
   logic                wr_req;
   logic                wr_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   lanes_in;
   logic                lane_oe;

   assign lanes_in = {SA_D3, SB_D2, SC_D1, IP_D0};

   // Lanes turn around combinationally on READFD so data is valid in the same cycle.
   assign lane_oe = READFD && ((state_q == S_OPEN) || (state_q == S_READ));

   assign SA_D3 = lane_oe ? rdata_q[4*SEG_W-1 -: SEG_W] : {SEG_W{1'bz}};
   assign SB_D2 = lane_oe ? rdata_q[3*SEG_W-1 -: SEG_W] : {SEG_W{1'bz}};
   assign SC_D1 = lane_oe ? rdata_q[2*SEG_W-1 -: SEG_W] : {SEG_W{1'bz}};
   assign IP_D0 = lane_oe ? rdata_q[1*SEG_W-1 -: SEG_W] : {SEG_W{1'bz}};

   assign BUSY_line_SLAVE = busy_q;
   assign PROT_ERR        = prot_err_q;
   assign BEAT_CNT        = beat_cnt_q;

   // A reset cycle must never commit a write.
   assign wr_en = wr_req && !RESET;

   // The RAM reads the next pointer so rdata_q always tracks RAM[ptr_q] one edge later.
   assign rd_addr = RESET ? '0 : ptr_d;

   // Phase sequencing: next state, acknowledge line, pointer and beat bookkeeping.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      prot_err_d = 1'b0;
      beat_cnt_d = beat_cnt_q;
      ptr_d      = ptr_q;
      dly_d      = dly_q;
      wr_req     = 1'b0;

      case (state_q)
         S_IDLE, S_OPEN: begin
            if (ADDRFD && !BUSY_line_MASTER) begin
               // Address phase wins over any other strobe in the same cycle.
               ptr_d      = lanes_in[ADDR_W-1:0];
               busy_d     = 1'b0;
               dly_d      = '0;
               state_d    = S_AWAIT;
               prot_err_d = WRITEFD || READFD;
            end else if (WRITEFD && !BUSY_line_MASTER) begin
               if (state_q == S_OPEN) begin
                  wr_req  = 1'b1;
                  busy_d  = 1'b0;
                  dly_d   = '0;
                  state_d = S_WAWAIT;
               end else begin
                  prot_err_d = 1'b1;
               end
            end else if (READFD) begin
               if (state_q == S_OPEN) begin
                  beat_cnt_d = '0;
                  busy_d     = 1'b0;
                  dly_d      = '0;
                  state_d    = S_READ;
               end else begin
                  prot_err_d = 1'b1;
               end
            end
         end

         S_AWAIT, S_WAWAIT: begin
            if (dly_q == c_ack_last) begin
               busy_d  = 1'b1;
               dly_d   = '0;
               state_d = S_OPEN;
            end else begin
               dly_d = dly_q + 4'd1;
            end
         end

         S_READ: begin
            if (busy_q) begin
               // Beat cycle ends: advance regardless of READFD so the beat is consumed.
               busy_d = 1'b0;
               dly_d  = '0;
               ptr_d  = ptr_q + ADDR_W'(1);
               if (beat_cnt_q != c_beat_max) begin
                  beat_cnt_d = beat_cnt_q + (ADDR_W+1)'(1);
               end
               if (!READFD) begin
                  busy_d  = 1'b1;
                  state_d = S_OPEN;
               end
            end else if (!READFD) begin
               busy_d  = 1'b1;
               dly_d   = '0;
               state_d = S_OPEN;
            end else if (dly_q == c_gap_last) begin
               busy_d = 1'b1;
               dly_d  = '0;
            end else begin
               dly_d = dly_q + 4'd1;
            end
         end

         default: begin
            busy_d  = 1'b1;
            dly_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge CLK_B) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b1;
         prot_err_q <= 1'b0;
         beat_cnt_q <= '0;
         ptr_q      <= '0;
         dly_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         prot_err_q <= prot_err_d;
         beat_cnt_q <= beat_cnt_d;
         ptr_q      <= ptr_d;
         dly_q      <= dly_d;
      end
   end

   // Block RAM: registered read, contents untouched by reset.
   always_ff @(posedge CLK_B) begin
      if (wr_en) begin
         mem[ptr_q] <= lanes_in;
      end
      rdata_q <= mem[rd_addr];
   end

endmodule
`default_nettype wire
